fns_cac_encoder: RTL and testbench

//  Sequential Fibonacci-number-system (FNS) CAC encoder, directly downstream of the FNS adder chain.

---
 rtl/fns_cac_encoder.sv | 208 ++++++++++++++++++++
 tb/tb_fns_cac_encoder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fns_cac_encoder.sv
// fns_cac_encoder: sequential Fibonacci-number-system CAC encoder.
// Maps a binary word onto the enabled TSVs by greedy MSB-first subtraction,
// one TSV per cycle, and presents the resulting codeword with a
// valid/ready handshake. Disabled TSVs are always driven 0.
//
// Optional build macro: FNS_CAC_ADJ_CHECK_EN -- when defined, a codeword
// with two adjacent ones is reported as an error (out_err=1, out_cw=0).
//
// Ports:
//   clk, rst             clock (rising edge), async active-high reset
//   in_valid/in_ready    input handshake; in_ready high only in IDLE
//   in_data  [DATA_W]    binary word to encode
//   en_flag  [N_TSV]     1 = TSV usable
//   fns_w    [N_TSV*W_W] weight of TSV i at [i*W_W +: W_W]
//   cap      [W_W]       exclusive upper bound of encodable values
//   out_valid/out_ready  output handshake
//   out_cw   [N_TSV]     codeword, bit i drives TSV i
//   out_err  [1]         word not encodable; out_cw forced 0
module fns_cac_encoder #(
  parameter int unsigned N_TSV  = 9,
  parameter int unsigned W_W    = 7,
  parameter int unsigned DATA_W = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [N_TSV-1:0]       en_flag,
  input  logic [N_TSV*W_W-1:0]   fns_w,
  input  logic [W_W-1:0]         cap,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N_TSV-1:0]       out_cw,
  output logic                   out_err
);

  localparam int unsigned CMP_W = (DATA_W > W_W) ? DATA_W : W_W;
  localparam int unsigned IDX_W = (N_TSV > 1) ? $clog2(N_TSV) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [CMP_W-1:0]       rem_q, rem_d;
  logic [N_TSV-1:0]       cw_q, cw_d;
  logic                   err_q, err_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [N_TSV-1:0]       en_q, en_d;
  logic [N_TSV*W_W-1:0]   w_q, w_d;

  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic [N_TSV-1:0]       out_cw_q, out_cw_d;
  logic                   out_err_q, out_err_d;

  logic                   accept;
  logic                   out_hs;

  assign accept    = in_valid & in_ready_q;
  assign out_hs    = out_valid_q & out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_cw    = out_cw_q;
  assign out_err   = out_err_q;

  // State, datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      cw_q        <= '0;
      err_q       <= 1'b0;
      idx_q       <= '0;
      en_q        <= '0;
      w_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_cw_q    <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      cw_q        <= cw_d;
      err_q       <= err_d;
      idx_q       <= idx_d;
      en_q        <= en_d;
      w_q         <= w_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_cw_q    <= out_cw_d;
      out_err_q   <= out_err_d;
    end
  end

  // Next state and datapath: snapshot on accept, one greedy step per ENC cycle
  always_comb begin
    logic [CMP_W-1:0] w_cur;
    logic             en_cur;
    logic             take;
    logic [N_TSV-1:0] cw_next;
    logic [CMP_W-1:0] rem_next;
    logic             adj;

    state_d  = state_q;
    rem_d    = rem_q;
    cw_d     = cw_q;
    err_d    = err_q;
    idx_d    = idx_q;
    en_d     = en_q;
    w_d      = w_q;
    w_cur    = '0;
    en_cur   = 1'b0;
    take     = 1'b0;
    cw_next  = cw_q;
    rem_next = rem_q;
    adj      = 1'b0;

    // Select the weight and enable of the TSV under the cursor
    for (int i = 0; i < N_TSV; i++) begin
      if (IDX_W'(i) == idx_q) begin
        w_cur  = CMP_W'(w_q[i*W_W +: W_W]);
        en_cur = en_q[i];
      end
    end

    take = en_cur & (rem_q >= w_cur);
    for (int i = 0; i < N_TSV; i++) begin
      if (IDX_W'(i) == idx_q) cw_next[i] = take;
    end
    rem_next = take ? (rem_q - w_cur) : rem_q;

`ifdef FNS_CAC_ADJ_CHECK_EN
    // Two ones on physically adjacent TSVs means the weight set is bad
    for (int i = 0; i < N_TSV - 1; i++) begin
      adj = adj | (cw_next[i] & cw_next[i+1]);
    end
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          en_d  = en_flag;
          w_d   = fns_w;
          cw_d  = '0;
          idx_d = IDX_W'(N_TSV - 1);
          if (CMP_W'(in_data) >= CMP_W'(cap)) begin
            rem_d   = '0;
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            rem_d   = CMP_W'(in_data);
            err_d   = 1'b0;
            state_d = ENC;
          end
        end
      end
      ENC: begin
        rem_d = rem_next;
        cw_d  = cw_next;
        if (idx_q == '0) begin
          // Last TSV: a leftover residue (or adjacency) invalidates the word
          state_d = DONE;
          if ((rem_next != '0) || adj) begin
            err_d = 1'b1;
            cw_d  = '0;
          end
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      DONE: begin
        if (out_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: follow the registered state one cycle later
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    out_cw_d    = out_cw_q;
    out_err_d   = out_err_q;
    case (state_q)
      IDLE: begin
        in_ready_d = ~accept;
      end
      ENC: begin
        in_ready_d = 1'b0;
      end
      DONE: begin
        if (!out_hs) begin
          out_valid_d = 1'b1;
          out_cw_d    = cw_q;
          out_err_d   = err_q;
        end
      end
      default: begin
        in_ready_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fns_cac_encoder.sv
// tb_fns_cac_encoder: directed self-checking bench for fns_cac_encoder.
module tb_fns_cac_encoder;

  localparam int unsigned N_TSV  = 9;
  localparam int unsigned W_W    = 7;
  localparam int unsigned DATA_W = 7;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_W-1:0]    in_data;
  logic [N_TSV-1:0]     en_flag;
  logic [N_TSV*W_W-1:0] fns_w;
  logic [W_W-1:0]       cap;
  logic                 out_valid;
  logic                 out_ready;
  logic [N_TSV-1:0]     out_cw;
  logic                 out_err;

  int checks   = 0;
  int failures = 0;

  logic [N_TSV*W_W-1:0] w_fib, w_t2, w_ones, w_zero;

  fns_cac_encoder #(.N_TSV(N_TSV), .W_W(W_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .en_flag   (en_flag),
    .fns_w     (fns_w),
    .cap       (cap),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_cw    (out_cw),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  function automatic logic [N_TSV*W_W-1:0] pack9(input int v[9]);
    logic [N_TSV*W_W-1:0] r;
    r = '0;
    for (int i = 0; i < 9; i++) r[i*W_W +: W_W] = W_W'(v[i]);
    return r;
  endfunction

  // Offer one word, scramble the inputs after accept, count cycles to out_valid
  task automatic send_word(input logic [DATA_W-1:0] d, input logic [N_TSV-1:0] en,
                           input logic [N_TSV*W_W-1:0] w, input logic [W_W-1:0] c,
                           output int lat);
    int k;
    k = 0;
    while (!in_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    in_valid = 1'b1;
    in_data  = d;
    en_flag  = en;
    fns_w    = w;
    cap      = c;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = d ^ 7'h55;
    en_flag  = ~en;
    fns_w    = ~w;
    cap      = ~c;
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    if (k >= 20) lat = 99;
  endtask

  // Take the codeword and let the encoder return to ready
  task automatic take_word();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    en_flag   = '0;
    fns_w     = '0;
    cap       = '0;
    out_ready = 1'b0;
    #12;
    checks += 4;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    if (out_cw !== 9'h000) begin failures++; $display("FAIL reset_out_cw got=%h exp=000", out_cw); end
    if (out_err !== 1'b0) begin failures++; $display("FAIL reset_out_err got=%b exp=0", out_err); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_vector(input string name, input logic [DATA_W-1:0] d,
                             input logic [N_TSV-1:0] en, input logic [N_TSV*W_W-1:0] w,
                             input logic [W_W-1:0] c, input logic [N_TSV-1:0] exp_cw,
                             input logic exp_err, input int exp_lat);
    int lat;
    send_word(d, en, w, c, lat);
    checks += 3;
    if (lat !== exp_lat) begin failures++; $display("FAIL %s latency got=%0d exp=%0d", name, lat, exp_lat); end
    if (out_cw !== exp_cw) begin failures++; $display("FAIL %s out_cw got=%h exp=%h", name, out_cw, exp_cw); end
    if (out_err !== exp_err) begin failures++; $display("FAIL %s out_err got=%b exp=%b", name, out_err, exp_err); end
    take_word();
  endtask

  task automatic test_hold();
    int lat;
    send_word(7'd50, 9'h1FF, w_fib, 7'd89, lat);
    for (int i = 0; i < 5; i++) begin
      checks += 3;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL hold_valid cyc=%0d got=%b exp=1", i, out_valid); end
      if (out_cw !== 9'h0A4) begin failures++; $display("FAIL hold_cw cyc=%0d got=%h exp=0a4", i, out_cw); end
      if (in_ready !== 1'b0) begin failures++; $display("FAIL hold_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks += 2;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL hs_valid_drop got=%b exp=0", out_valid); end
    if (in_ready !== 1'b0) begin failures++; $display("FAIL hs_no_same_cycle got=%b exp=0", in_ready); end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL hs_in_ready_next got=%b exp=1", in_ready); end
  endtask

  task automatic test_reset_mid_enc();
    in_valid = 1'b1;
    in_data  = 7'd50;
    en_flag  = 9'h1FF;
    fns_w    = w_fib;
    cap      = 7'd89;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Accept edge loads idx=8; four more edges leave idx=4 under the cursor
    repeat (4) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    checks += 2;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_stale_valid got=%b exp=0", out_valid); end
    end
    test_vector("after_reset_d7", 7'd7, 9'h1FF, w_fib, 7'd89, 9'h00A, 1'b0, 10);
  endtask

  initial begin
    int fib[9]  = '{1, 2, 3, 5, 8, 13, 21, 34, 55};
    int t2[9]   = '{1, 2, 3, 5, 8, 0, 13, 21, 34};
    int ones[9] = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    int zero[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    w_fib  = pack9(fib);
    w_t2   = pack9(t2);
    w_ones = pack9(ones);
    w_zero = pack9(zero);

    test_reset();
    test_vector("fib_d50",   7'd50, 9'h1FF, w_fib, 7'd89, 9'h0A4, 1'b0, 10);
    test_vector("tsv5_d50",  7'd50, 9'h1DF, w_t2,  7'd55, 9'h144, 1'b0, 10);
    test_vector("ovf_d89",   7'd89, 9'h1FF, w_fib, 7'd89, 9'h000, 1'b1, 1);
    test_vector("fib_d0",    7'd0,  9'h1FF, w_fib, 7'd89, 9'h000, 1'b0, 10);
    test_vector("fib_d88",   7'd88, 9'h1FF, w_fib, 7'd89, 9'h155, 1'b0, 10);
    test_vector("alldis_d1", 7'd1,  9'h000, w_fib, 7'd89, 9'h000, 1'b1, 10);
    test_vector("alldis_d0", 7'd0,  9'h000, w_fib, 7'd89, 9'h000, 1'b0, 10);
    test_vector("cap0_d0",   7'd0,  9'h1FF, w_fib, 7'd0,  9'h000, 1'b1, 1);
`ifdef FNS_CAC_ADJ_CHECK_EN
    test_vector("ones_d2",   7'd2,  9'h1FF, w_ones, 7'd89, 9'h000, 1'b1, 10);
    test_vector("zero_w_d0", 7'd0,  9'h1FF, w_zero, 7'd89, 9'h000, 1'b1, 10);
`else
    test_vector("ones_d2",   7'd2,  9'h1FF, w_ones, 7'd89, 9'h180, 1'b0, 10);
    test_vector("zero_w_d0", 7'd0,  9'h1FF, w_zero, 7'd89, 9'h1FF, 1'b0, 10);
`endif
    test_hold();
    test_reset_mid_enc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
